issue_select: RTL

- Select and allocation controller for the 16-entry compute issue queue (CIQ).
- Tracks per-entry valid, FU class, sticky source-ready bits and relative age. Each cycle it picks the oldest ready entry for ALU0, ALU1, MUL and LS.
- Drives the grant_*/addr_* pairs that the wake-up logic consumes.
- Also allocates free CIQ slots to dispatch and arbitrates a non-pipelined multiplier and a back-pressured load/store port.

---
 rtl/iq_pkg.sv | 28 ++
 rtl/issue_select_if.sv | 38 +++
 rtl/age_oldest_pick.sv | 29 ++
 rtl/issue_select.sv | 116 +++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iq_pkg
// Description : Shared FU encodings, CIQ sizing defaults and index helper.
// Revision    : 1.0 - initial release
// ============================================================================
package iq_pkg;

    localparam logic [1:0] FU_ALU = 2'd0;
    localparam logic [1:0] FU_MUL = 2'd1;
    localparam logic [1:0] FU_LS  = 2'd2;

    localparam int DEF_IQ_DEPTH  = 16;
    localparam int DEF_IDX_WIDTH = 5;

    function automatic logic [DEF_IDX_WIDTH-1:0] onehot_to_idx(
        input logic [DEF_IQ_DEPTH-1:0] onehot
    );
        logic [DEF_IDX_WIDTH-1:0] w_idx;
        w_idx = '0;
        for (int i = 0; i < DEF_IQ_DEPTH; i++) begin
            if (onehot[i]) w_idx = w_idx | DEF_IDX_WIDTH'(i);
        end
        return w_idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/issue_select_if.sv
`default_nettype none
// ============================================================================
// Module      : issue_select_if
// Description : Dispatch, wake-up and issue-grant bundle of the CIQ selector.
// Revision    : 1.0 - initial release
// ============================================================================
interface issue_select_if #(
    parameter int IQ_DEPTH  = iq_pkg::DEF_IQ_DEPTH,
    parameter int IDX_WIDTH = iq_pkg::DEF_IDX_WIDTH
);
    logic                 disp_valid;
    logic [1:0]           disp_fu;
    logic                 disp_prs1_rdy;
    logic                 disp_prs2_rdy;
    logic                 disp_ready;
    logic [IDX_WIDTH-1:0] disp_idx;
    logic [IQ_DEPTH-1:0]  wake_prs1;
    logic [IQ_DEPTH-1:0]  wake_prs2;
    logic                 ls_ready;
    logic                 grant_alu0, grant_alu1, grant_mul, grant_ls;
    logic [IDX_WIDTH-1:0] addr_alu0, addr_alu1, addr_mul, addr_ls;
    logic                 mul_busy;

    modport master (
        output disp_valid, disp_fu, disp_prs1_rdy, disp_prs2_rdy,
               wake_prs1, wake_prs2, ls_ready,
        input  disp_ready, disp_idx, grant_alu0, grant_alu1, grant_mul, grant_ls,
               addr_alu0, addr_alu1, addr_mul, addr_ls, mul_busy
    );

    modport slave (
        input  disp_valid, disp_fu, disp_prs1_rdy, disp_prs2_rdy,
               wake_prs1, wake_prs2, ls_ready,
        output disp_ready, disp_idx, grant_alu0, grant_alu1, grant_mul, grant_ls,
               addr_alu0, addr_alu1, addr_mul, addr_ls, mul_busy
    );
endinterface
`default_nettype wire

// File: rtl/age_oldest_pick.sv
`default_nettype none
// ============================================================================
// Module      : age_oldest_pick
// Description : One-hot pick of the requester with no older competing requester.
// Revision    : 1.0 - initial release
// ============================================================================
module age_oldest_pick #(
    parameter int IQ_DEPTH = iq_pkg::DEF_IQ_DEPTH
) (
    input  logic [IQ_DEPTH-1:0]               i_request,
    input  logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] i_age,
    output logic [IQ_DEPTH-1:0]               o_grant,
    output logic                              o_valid
);
    generate
        for (genvar i = 0; i < IQ_DEPTH; i++) begin : g_pick
            logic [IQ_DEPTH-1:0] w_older;
            // Column i of the matrix: which entries are older than entry i.
            always_comb begin
                w_older = '0;
                for (int j = 0; j < IQ_DEPTH; j++) w_older[j] = i_age[j][i];
            end
            assign o_grant[i] = i_request[i] & ~|(i_request & w_older);
        end
    endgenerate

    assign o_valid = |o_grant;
endmodule
`default_nettype wire

// File: rtl/issue_select.sv
`default_nettype none
// ============================================================================
// Module      : issue_select
// Description : CIQ allocation and oldest-ready select for ALU0/ALU1/MUL/LS.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_select
    import iq_pkg::*;
#(
    parameter int IQ_DEPTH  = DEF_IQ_DEPTH,
    parameter int IDX_WIDTH = DEF_IDX_WIDTH,
    parameter int MUL_LAT   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    issue_select_if.slave bus
);
    localparam int                 c_cnt_w      = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [c_cnt_w-1:0] c_mul_reload = c_cnt_w'(MUL_LAT - 1);

    logic [IQ_DEPTH-1:0]               r_valid, r_rdy1, r_rdy2;
    logic [IQ_DEPTH-1:0][1:0]          r_fu;
    logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] r_age;
    logic [c_cnt_w-1:0]                r_mul_cnt;

    logic [IQ_DEPTH-1:0] w_ready, w_req_alu, w_req_alu1, w_req_mul, w_req_ls;
    logic [IQ_DEPTH-1:0] w_pick_alu0, w_pick_alu1, w_pick_mul, w_pick_ls;
    logic                w_vld_alu0, w_vld_alu1, w_vld_mul, w_vld_ls;
    logic                w_gnt_alu0, w_gnt_alu1, w_gnt_mul, w_gnt_ls;
    logic [IQ_DEPTH-1:0] w_issued, w_disp_oh;
    logic                w_disp_ready, w_disp_fire, w_mul_busy;

    assign w_ready    = r_valid & r_rdy1 & r_rdy2;
    assign w_mul_busy = (r_mul_cnt != '0);

    always_comb begin
        w_req_alu = '0;
        w_req_mul = '0;
        w_req_ls  = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            w_req_alu[i] = w_ready[i] && (r_fu[i] == FU_ALU);
            w_req_mul[i] = w_ready[i] && (r_fu[i] == FU_MUL) && !w_mul_busy;
            w_req_ls[i]  = w_ready[i] && (r_fu[i] == FU_LS) && bus.ls_ready;
        end
    end

    assign w_req_alu1 = w_req_alu & ~w_pick_alu0;

    age_oldest_pick #(.IQ_DEPTH(IQ_DEPTH)) u_pick_alu0 (
        .i_request(w_req_alu),  .i_age(r_age), .o_grant(w_pick_alu0), .o_valid(w_vld_alu0));
    age_oldest_pick #(.IQ_DEPTH(IQ_DEPTH)) u_pick_alu1 (
        .i_request(w_req_alu1), .i_age(r_age), .o_grant(w_pick_alu1), .o_valid(w_vld_alu1));
    age_oldest_pick #(.IQ_DEPTH(IQ_DEPTH)) u_pick_mul (
        .i_request(w_req_mul),  .i_age(r_age), .o_grant(w_pick_mul),  .o_valid(w_vld_mul));
    age_oldest_pick #(.IQ_DEPTH(IQ_DEPTH)) u_pick_ls (
        .i_request(w_req_ls),   .i_age(r_age), .o_grant(w_pick_ls),   .o_valid(w_vld_ls));

    assign w_gnt_alu0 = w_vld_alu0 & ~flush;
    assign w_gnt_alu1 = w_vld_alu1 & ~flush;
    assign w_gnt_mul  = w_vld_mul  & ~flush;
    assign w_gnt_ls   = w_vld_ls   & ~flush;

    assign w_issued = (w_pick_alu0 & {IQ_DEPTH{w_gnt_alu0}}) | (w_pick_alu1 & {IQ_DEPTH{w_gnt_alu1}})
                    | (w_pick_mul  & {IQ_DEPTH{w_gnt_mul}})  | (w_pick_ls   & {IQ_DEPTH{w_gnt_ls}});

    // Lowest clear bit of the valid vector; zero when the queue is full.
    assign w_disp_oh    = ~r_valid & (r_valid + IQ_DEPTH'(1));
    assign w_disp_ready = ~&r_valid;
    assign w_disp_fire  = bus.disp_valid & w_disp_ready & ~flush;

    assign bus.disp_ready = w_disp_ready;
    assign bus.disp_idx   = onehot_to_idx(w_disp_oh);
    assign bus.grant_alu0 = w_gnt_alu0;
    assign bus.grant_alu1 = w_gnt_alu1;
    assign bus.grant_mul  = w_gnt_mul;
    assign bus.grant_ls   = w_gnt_ls;
    assign bus.addr_alu0  = w_gnt_alu0 ? onehot_to_idx(w_pick_alu0) : '0;
    assign bus.addr_alu1  = w_gnt_alu1 ? onehot_to_idx(w_pick_alu1) : '0;
    assign bus.addr_mul   = w_gnt_mul  ? onehot_to_idx(w_pick_mul)  : '0;
    assign bus.addr_ls    = w_gnt_ls   ? onehot_to_idx(w_pick_ls)   : '0;
    assign bus.mul_busy   = w_mul_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_rdy1  <= '0;
            r_rdy2  <= '0;
            r_fu    <= '0;
            r_age   <= '0;
        end else begin
            r_rdy1 <= r_rdy1 | (r_valid & bus.wake_prs1);
            r_rdy2 <= r_rdy2 | (r_valid & bus.wake_prs2);
            if (flush) r_valid <= '0;
            else       r_valid <= (r_valid & ~w_issued) | (w_disp_fire ? w_disp_oh : '0);
            for (int i = 0; i < IQ_DEPTH; i++) begin
                if (w_disp_fire && w_disp_oh[i]) begin
                    r_rdy1[i] <= bus.disp_prs1_rdy;
                    r_rdy2[i] <= bus.disp_prs2_rdy;
                    r_fu[i]   <= bus.disp_fu;
                    // Every surviving entry is older than the newcomer.
                    for (int j = 0; j < IQ_DEPTH; j++) r_age[j][i] <= r_valid[j] & ~w_issued[j];
                    r_age[i] <= '0;
                end
            end
        end
    end

    // The multiplier keeps counting through flush: the unit is still occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            r_mul_cnt <= '0;
        else if (w_gnt_mul)    r_mul_cnt <= c_mul_reload;
        else if (w_mul_busy)   r_mul_cnt <= r_mul_cnt - c_cnt_w'(1);
    end
endmodule
`default_nettype wire
